uk101_ps2_keymatrix: RTL and testbench

PS/2-to-matrix keyboard stage for the UK101 core. It consumes the PS/2 clock/data pair driven by `hps_io` and presents the UK101 8x8 active-low keyboard matrix. The CPU writes row strobes to $DF00 and reads column returns, so the emulated monitor and BASIC scan a real-looking keyboard. It sits between `hps_io` and the keyboard port of the `uk101` core, in the `clk_sys` domain.

---
 rtl/uk101_kbd_pkg.sv | 62 ++++++
 rtl/uk101_ps2_keymatrix_ps2_rx.sv | 96 +++++++++
 rtl/uk101_ps2_keymatrix.sv | 123 ++++++++++++
 tb/tb_uk101_ps2_keymatrix.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uk101_kbd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : uk101_kbd_pkg                                             |
// | Purpose  : Shared types and scancode table for the UK101 PS/2 to     |
// |            keyboard-matrix stage: decoder state enum, key position   |
// |            struct, PS/2 set-2 prefix constants, scancode map.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package uk101_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  localparam logic [7:0] C_SC_E0   = 8'hE0;
  localparam logic [7:0] C_SC_F0   = 8'hF0;
  localparam logic [7:0] C_SC_E1   = 8'hE1;
  localparam logic [7:0] C_SC_CAPS = 8'h58;
  // E1 introduces the 8-byte Pause sequence; the remaining 7 bytes are eaten.
  localparam logic [2:0] C_SKIP_LEN = 3'd7;

  // {ext, code} -> matrix position; rc is written in octal as row,col.
  // CapsLock is absent on purpose: it toggles the shift-lock bit instead.
  function automatic key_pos_t map_scancode(input logic ext, input logic [7:0] code);
    logic [5:0] rc;
    logic       hit;
    hit = 1'b1;
    rc  = 6'o00;
    case ({ext, code})
      9'h059: rc = 6'o01;  9'h012: rc = 6'o02;  9'h076: rc = 6'o05;  9'h014: rc = 6'o06;
      9'h114: rc = 6'o06;  9'h005: rc = 6'o07;
      9'h04D: rc = 6'o11;  9'h04C: rc = 6'o12;  9'h04A: rc = 6'o13;  9'h029: rc = 6'o14;
      9'h01A: rc = 6'o15;  9'h01C: rc = 6'o16;  9'h015: rc = 6'o17;
      9'h041: rc = 6'o21;  9'h03A: rc = 6'o22;  9'h031: rc = 6'o23;  9'h032: rc = 6'o24;
      9'h02A: rc = 6'o25;  9'h021: rc = 6'o26;  9'h022: rc = 6'o27;
      9'h042: rc = 6'o31;  9'h03B: rc = 6'o32;  9'h033: rc = 6'o33;  9'h034: rc = 6'o34;
      9'h02B: rc = 6'o35;  9'h023: rc = 6'o36;  9'h01B: rc = 6'o37;
      9'h043: rc = 6'o41;  9'h03C: rc = 6'o42;  9'h035: rc = 6'o43;  9'h02C: rc = 6'o44;
      9'h02D: rc = 6'o45;  9'h024: rc = 6'o46;  9'h01D: rc = 6'o47;
      9'h05A: rc = 6'o51;  9'h15A: rc = 6'o51;  9'h05B: rc = 6'o52;  9'h054: rc = 6'o53;
      9'h044: rc = 6'o54;  9'h04B: rc = 6'o55;  9'h049: rc = 6'o56;
      9'h066: rc = 6'o61;  9'h04E: rc = 6'o62;  9'h052: rc = 6'o63;  9'h045: rc = 6'o64;
      9'h046: rc = 6'o65;  9'h03E: rc = 6'o66;
      9'h03D: rc = 6'o71;  9'h036: rc = 6'o72;  9'h02E: rc = 6'o73;  9'h025: rc = 6'o74;
      9'h026: rc = 6'o75;  9'h01E: rc = 6'o76;  9'h016: rc = 6'o77;
      default: hit = 1'b0;
    endcase
    return {hit, rc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uk101_ps2_keymatrix_ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx                                                    |
// | Purpose  : PS/2 device-to-host byte receiver. Synchronises the pins, |
// |            shifts 11-bit frames on falling ps2Clk, drops frames with |
// |            a bad start/stop bit and abandons stalled frames.         |
// | Ports    : clk, n_reset (sync, active-low), ps2Clk, ps2Data (async), |
// |            byte_valid (1-cycle pulse), byte_data (held).             |
// | Macro    : UK101_PS2_PARITY_EN - also drop frames failing odd parity |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int               C_IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_IDLE_W-1:0] C_TIMEOUT = C_IDLE_W'(TIMEOUT_CYCLES);

  logic                r_clk_s1, r_clk_s2, r_clk_s3;
  logic                r_dat_s1, r_dat_s2;
  logic [9:0]          r_shift;   // bits received so far, newest at the top
  logic [3:0]          r_bitcnt;
  logic [C_IDLE_W-1:0] r_idle;

  logic        w_fall;
  logic [10:0] w_frame;
  logic        w_parity_ok;
  logic        w_frame_ok;

  assign w_fall  = r_clk_s3 & ~r_clk_s2;
  // Full frame as it will look once the current data bit is shifted in:
  // [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign w_frame = {r_dat_s2, r_shift};

`ifdef UK101_PS2_PARITY_EN
  assign w_parity_ok = ^w_frame[9:1];
`else
  logic w_unused_parity;
  assign w_unused_parity = w_frame[9];
  assign w_parity_ok     = 1'b1;
`endif

  assign w_frame_ok = ~w_frame[0] & w_frame[10] & w_parity_ok;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      // Synchronisers rest at the idle-high line level so reset never
      // fabricates a falling edge.
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_s3   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_idle     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      r_clk_s1   <= ps2Clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_s3   <= r_clk_s2;
      r_dat_s1   <= ps2Data;
      r_dat_s2   <= r_dat_s1;
      byte_valid <= 1'b0;
      // The edge branch comes first so a frame finishing on the timeout
      // clock still completes.
      if (w_fall) begin
        r_idle <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          if (w_frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= w_frame[8:1];
          end
        end else begin
          r_shift  <= w_frame[10:1];
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_idle == C_TIMEOUT) begin
        r_bitcnt <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uk101_ps2_keymatrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uk101_ps2_keymatrix                                       |
// | Purpose  : PS/2 keyboard to UK101 8x8 active-low key matrix. Decodes |
// |            make/break/extended prefixes into a 64-bit pressed-key    |
// |            register and returns column data for the row strobe.      |
// | Ports    : clk, n_reset (sync, active-low), ps2Clk, ps2Data,         |
// |            row_n[7:0] in, col_n[7:0] out (registered),               |
// |            code_strobe (1-cycle per byte), code[7:0] (last byte).    |
// | Macro    : UK101_PS2_PARITY_EN - enables odd-parity frame check      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module uk101_ps2_keymatrix
  import uk101_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic [7:0] row_n,
  output logic [7:0] col_n,
  output logic       code_strobe,
  output logic [7:0] code
);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .n_reset    (n_reset),
    .ps2Clk     (ps2Clk),
    .ps2Data    (ps2Data),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data)
  );

  kbd_state_t r_state;
  logic [2:0] r_skip;
  logic [63:0] r_keys;       // bit row*8+col, 1 = pressed; bit 0 is shift lock
  logic [7:0] r_col_n;
  logic       r_code_strobe;
  logic [7:0] r_code;

  logic       w_act;         // current byte is a key event (not a prefix)
  logic       w_ext;
  logic       w_brk;
  key_pos_t   w_pos;
  logic [7:0] w_col_n;

  always_comb begin
    w_act = 1'b0;
    w_ext = 1'b0;
    w_brk = 1'b0;
    case (r_state)
      ST_IDLE:    w_act = (w_byte_data != C_SC_E0) && (w_byte_data != C_SC_F0) &&
                          (w_byte_data != C_SC_E1);
      ST_EXT:     begin w_act = (w_byte_data != C_SC_F0); w_ext = 1'b1; end
      ST_BRK:     begin w_act = 1'b1; w_brk = 1'b1; end
      ST_EXT_BRK: begin w_act = 1'b1; w_ext = 1'b1; w_brk = 1'b1; end
      default:    w_act = 1'b0;
    endcase
  end

  assign w_pos = map_scancode(w_ext, w_byte_data);

  always_comb begin
    w_col_n = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (!row_n[r] && r_keys[8*r + c]) w_col_n[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state       <= ST_IDLE;
      r_skip        <= '0;
      r_keys        <= 64'h1;   // shift lock engaged for the upper-case monitor
      r_col_n       <= 8'hFF;
      r_code_strobe <= 1'b0;
      r_code        <= '0;
    end else begin
      r_col_n       <= w_col_n;
      r_code_strobe <= w_byte_valid;
      if (w_byte_valid) begin
        r_code <= w_byte_data;
        case (r_state)
          ST_IDLE: begin
            if (w_byte_data == C_SC_E0)      r_state <= ST_EXT;
            else if (w_byte_data == C_SC_F0) r_state <= ST_BRK;
            else if (w_byte_data == C_SC_E1) begin
              r_state <= ST_SKIP;
              r_skip  <= C_SKIP_LEN;
            end
          end
          ST_EXT:  r_state <= (w_byte_data == C_SC_F0) ? ST_EXT_BRK : ST_IDLE;
          ST_SKIP: begin
            r_skip <= r_skip - 3'd1;
            if (r_skip <= 3'd1) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_act) begin
          if (!w_ext && (w_byte_data == C_SC_CAPS)) begin
            if (!w_brk) r_keys[0] <= ~r_keys[0];
          end else if (w_pos.hit) begin
            r_keys[{w_pos.row, w_pos.col}] <= ~w_brk;
          end
        end
      end
    end
  end

  assign col_n       = r_col_n;
  assign code_strobe = r_code_strobe;
  assign code        = r_code;

endmodule
`default_nettype wire

// File: tb/tb_uk101_ps2_keymatrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uk101_ps2_keymatrix                                    |
// | Purpose  : Self-checking bench: directed scenarios plus randomized   |
// |            key make/break traffic against a pressed-key model.       |
// | Macro    : UK101_PS2_PARITY_EN - selects the bad-parity expectation  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_uk101_ps2_keymatrix;

  localparam int TIMEOUT = 50000;
  localparam int HALF    = 8;      // PS/2 half bit period in system clocks

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] row_n = 8'hFF;
  logic [7:0] col_n;
  logic       code_strobe;
  logic [7:0] code;

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  uk101_ps2_keymatrix #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .row_n       (row_n),
    .col_n       (col_n),
    .code_strobe (code_strobe),
    .code        (code)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (code_strobe === 1'b1) strobes++;

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2Data = b;
    clocks(HALF);
    ps2Clk = 1'b0;
    clocks(HALF);
    ps2Clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    clocks(6);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    row_n   = 8'hFF;
    clocks(3);
    n_reset = 1'b1;
    clocks(2);
  endtask

  task automatic set_row(input logic [7:0] r);
    row_n = r;
    clocks(2);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (col_n !== 8'hFF) begin bad++; $display("FAIL reset_col got=%h want=ff", col_n); end
    total++; if (code !== 8'h00 || code_strobe !== 1'b0) begin
      bad++; $display("FAIL reset_code got=%h/%b want=00/0", code, code_strobe); end
    set_row(8'hFE);
    total++; if (col_n !== 8'hFE) begin bad++; $display("FAIL reset_shiftlock got=%h want=fe", col_n); end
    set_row(8'hFF);
    total++; if (col_n !== 8'hFF) begin bad++; $display("FAIL rows_high got=%h want=ff", col_n); end
  endtask

  task automatic test_letter();
    int s0;
    do_reset();
    s0 = strobes;
    send_byte(8'h1C, 1'b0);
    total++; if (code !== 8'h1C) begin bad++; $display("FAIL code_held got=%h want=1c", code); end
    set_row(8'hFD);
    total++; if (col_n !== 8'hBF) begin bad++; $display("FAIL letter_make got=%h want=bf", col_n); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    total++; if (col_n !== 8'hFF) begin bad++; $display("FAIL letter_break got=%h want=ff", col_n); end
    total++; if (strobes - s0 != 3) begin bad++; $display("FAIL strobe_count got=%0d want=3", strobes - s0); end
  endtask

  task automatic test_shift();
    do_reset();
    send_byte(8'h12, 1'b0);
    send_byte(8'h59, 1'b0);
    set_row(8'hFE);
    total++; if (col_n !== 8'hF8) begin bad++; $display("FAIL shifts got=%h want=f8", col_n); end
    send_byte(8'h58, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h58, 1'b0);
    total++; if (col_n !== 8'hF9) begin bad++; $display("FAIL capslock got=%h want=f9", col_n); end
    set_row(8'h00);
    total++; if (col_n !== 8'hF9) begin bad++; $display("FAIL all_rows got=%h want=f9", col_n); end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h14, 1'b0);
    set_row(8'hFE);
    total++; if (col_n !== 8'hBE) begin bad++; $display("FAIL ext_make got=%h want=be", col_n); end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h14, 1'b0);
    total++; if (col_n !== 8'hFE) begin bad++; $display("FAIL ext_break got=%h want=fe", col_n); end
  endtask

  task automatic test_timeout();
    int s0;
    do_reset();
    s0 = strobes;
    for (int i = 0; i < 5; i++) ps2_bit(1'(i == 0 ? 0 : 1));
    clocks(TIMEOUT + 10);
    send_byte(8'h76, 1'b0);
    set_row(8'hFE);
    total++; if (col_n !== 8'hDE) begin bad++; $display("FAIL timeout_key got=%h want=de", col_n); end
    total++; if (strobes - s0 != 1 || code !== 8'h76) begin
      bad++; $display("FAIL timeout_stray got=%0d/%h want=1/76", strobes - s0, code); end
  endtask

  task automatic test_reset_midframe();
    int s0;
    do_reset();
    for (int i = 0; i < 6; i++) ps2_bit(1'(i == 0 ? 0 : 1));
    do_reset();
    s0 = strobes;
    send_byte(8'h1C, 1'b0);
    set_row(8'hFD);
    total++; if (col_n !== 8'hBF || strobes - s0 != 1) begin
      bad++; $display("FAIL midframe_reset got=%h/%0d want=bf/1", col_n, strobes - s0); end
  endtask

  task automatic test_pause_skip();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    foreach (seq[i]) send_byte(seq[i], 1'b0);
    send_byte(8'h1C, 1'b0);
    set_row(8'hFE);
    total++; if (col_n !== 8'hFE) begin bad++; $display("FAIL pause_row0 got=%h want=fe", col_n); end
    set_row(8'hFD);
    total++; if (col_n !== 8'hBF) begin bad++; $display("FAIL pause_after got=%h want=bf", col_n); end
  endtask

  task automatic test_parity();
    int s0;
    do_reset();
    s0 = strobes;
    send_byte(8'h1C, 1'b1);
    set_row(8'hFD);
`ifdef UK101_PS2_PARITY_EN
    total++; if (strobes - s0 != 0 || col_n !== 8'hFF) begin
      bad++; $display("FAIL parity_drop got=%0d/%h want=0/ff", strobes - s0, col_n); end
`else
    total++; if (strobes - s0 != 1 || col_n !== 8'hBF) begin
      bad++; $display("FAIL parity_ignored got=%0d/%h want=1/bf", strobes - s0, col_n); end
`endif
  endtask

  // Known keys: {ext, code, matrix index}; the last entry is CapsLock.
  task automatic test_random();
    bit         pressed [64];
    logic [7:0] kcode [7] = '{8'h12, 8'h59, 8'h14, 8'h14, 8'h76, 8'h1C, 8'h58};
    bit         kext  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int         kidx  [7] = '{2, 1, 6, 6, 5, 14, 0};
    do_reset();
    foreach (pressed[i]) pressed[i] = (i == 0);
    for (int n = 0; n < 30; n++) begin
      int k, s0, nbytes;
      bit mk;
      logic [7:0] rn, exp;
      k  = $urandom_range(0, 6);
      mk = 1'($urandom_range(0, 1));
      s0 = strobes;
      nbytes = 1;
      if (kext[k]) begin send_byte(8'hE0, 1'b0); nbytes++; end
      if (!mk)     begin send_byte(8'hF0, 1'b0); nbytes++; end
      send_byte(kcode[k], 1'b0);
      if (k == 6) begin if (mk) pressed[0] = ~pressed[0]; end
      else pressed[kidx[k]] = mk;
      rn = 8'($urandom_range(0, 255));
      set_row(rn);
      exp = 8'hFF;
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++)
          if (!rn[r] && pressed[8*r + c]) exp[c] = 1'b0;
      total++; if (col_n !== exp) begin
        bad++; $display("FAIL random_col step=%0d row=%h got=%h want=%h", n, rn, col_n, exp); end
      total++; if (strobes - s0 != nbytes) begin
        bad++; $display("FAIL random_strobes step=%0d got=%0d want=%0d", n, strobes - s0, nbytes); end
    end
  endtask

  initial begin
    test_reset();
    test_letter();
    test_shift();
    test_extended();
    test_timeout();
    test_reset_midframe();
    test_pause_skip();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
